// File: rtl/fdc_and_fdr_pkg.sv
// Shared constants for the fdc_and_fdr register pair.
// Names the two clear styles so fd_cell instances read clearly at the call site.
package fdc_and_fdr_pkg;

  // Default data width of the register pair.
  localparam int DEFAULT_WIDTH = 1;

  // Clear style selectors for fd_cell.ASYNC_CLR.
  localparam bit CLR_ASYNC = 1'b1;  // FDC: clear acts immediately
  localparam bit CLR_SYNC  = 1'b0;  // FDR: clear acts only at a rising edge

endpackage : fdc_and_fdr_pkg

// File: rtl/fdc_and_fdr_if.sv
// Data/clear/output bundle of the fdc_and_fdr register pair.
// master drives d and rc and observes both outputs; slave is the register block.
interface fdc_and_fdr_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;   // shared data input
  logic             rc;  // active-high clear
  logic [WIDTH-1:0] qc;  // async-clear (FDC) output
  logic [WIDTH-1:0] qr;  // sync-clear (FDR) output

  modport master (
    output d,
    output rc,
    input  qc,
    input  qr
  );

  modport slave (
    input  d,
    input  rc,
    output qc,
    output qr
  );

endinterface : fdc_and_fdr_if

// File: rtl/fdc_and_fdr_fd_cell.sv
// WIDTH-bit D register with a selectable clear style.
// ASYNC_CLR=1 gives an FDC-style register (clear acts without a clock);
// ASYNC_CLR=0 gives an FDR-style register (clear sampled at the rising edge).
// rst_n always acts asynchronously and outranks the clear and the data.
module fd_cell
  import fdc_and_fdr_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit ASYNC_CLR = CLR_ASYNC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             rc,
  output logic [WIDTH-1:0] q
);

  // Value loaded by both reset and clear.
  localparam logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;

  if (ASYNC_CLR) begin : g_async_clr
    // FDC register: rc sits in the sensitivity list, so it clears immediately
    // and holds the flop at zero until an edge with rc low samples d.
    always_ff @(posedge clk or negedge rst_n or posedge rc) begin
      if (!rst_n) begin
        q_r <= CLR_VAL;
      end else if (rc) begin
        q_r <= CLR_VAL;
      end else begin
        q_r <= d;
      end
    end
  end else begin : g_sync_clr
    // FDR register: rc is only an input to the D-side mux, so pulses that
    // cover no rising edge leave the stored value alone.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_r <= CLR_VAL;
      end else if (rc) begin
        q_r <= CLR_VAL;
      end else begin
        q_r <= d;
      end
    end
  end

  assign q = q_r;

endmodule : fd_cell

// File: rtl/fdc_and_fdr.sv
// Pair of D registers sharing d, clk, rc and rst_n.
// qc clears asynchronously on rc (FDC), qr clears synchronously on rc (FDR).
// Both outputs come straight from flops; the only combinational path is
// rc into the async clear pin of the qc register.
module fdc_and_fdr
  import fdc_and_fdr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  fdc_and_fdr_if.slave      bus
);

  logic [WIDTH-1:0] qc_s;
  logic [WIDTH-1:0] qr_s;

  fd_cell #(
    .WIDTH     (WIDTH),
    .ASYNC_CLR (CLR_ASYNC)
  ) u_fdc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.d),
    .rc    (bus.rc),
    .q     (qc_s)
  );

  fd_cell #(
    .WIDTH     (WIDTH),
    .ASYNC_CLR (CLR_SYNC)
  ) u_fdr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.d),
    .rc    (bus.rc),
    .q     (qr_s)
  );

  assign bus.qc = qc_s;
  assign bus.qr = qr_s;

endmodule : fdc_and_fdr

// File: tb/tb_fdc_and_fdr.sv
// Directed bench for fdc_and_fdr (WIDTH=1, 40 ns clock, first rise at 20 ns).
// Stimulus pushes hand-computed expectations into a queue and raises a sample
// event; an independent monitor pops each entry and compares the outputs.
`timescale 1ns/1ps
module tb_fdc_and_fdr;

  logic clk;
  logic rst_n;

  fdc_and_fdr_if #(.WIDTH(1)) bus ();

  fdc_and_fdr #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string    name;
    logic     qc;
    logic     qr;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Clock: rising edges at 20, 60, 100, ... ns.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Advance to an absolute simulation time.
  task automatic goto(input int t);
    if (t > $time) #(t - $time);
  endtask

  // Queue an expectation and ask the monitor to sample now.
  task automatic expect_q(input string name, input logic eqc, input logic eqr);
    exp_t e;
    e.name = name;
    e.qc   = eqc;
    e.qr   = eqr;
    sb_q.push_back(e);
    -> sample_ev;
  endtask

  // Monitor: drain the scoreboard whenever a sample is requested.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.qc !== e.qc || bus.qr !== e.qr) begin
          n_fail++;
          $display("FAIL %s @%0t: qc=%b qr=%b, expected qc=%b qr=%b",
                   e.name, $time, bus.qc, bus.qr, e.qc, e.qr);
        end
      end
    end
  end

  // Stimulus: directed timeline with expected outputs computed by hand.
  initial begin
    rst_n  = 1'b0;
    bus.d  = 1'b0;
    bus.rc = 1'b0;

    // Reset holds both outputs at 0 while d toggles across edges.
    goto(1);   expect_q("reset_t1", 1'b0, 1'b0);
    goto(10);  bus.d = 1'b1;
    goto(21);  expect_q("reset_edge20", 1'b0, 1'b0);
    goto(50);  bus.d = 1'b0;
    goto(55);  bus.d = 1'b1;
    goto(61);  expect_q("reset_edge60", 1'b0, 1'b0);

    // Release mid-cycle: outputs wait for the next edge to sample d.
    goto(80);  rst_n = 1'b1;
    goto(85);  expect_q("rel_before_edge_a", 1'b0, 1'b0);
    goto(99);  expect_q("rel_before_edge_b", 1'b0, 1'b0);
    goto(101); expect_q("rel_edge100", 1'b1, 1'b1);

    // Load/track.
    goto(105); bus.d = 1'b1;
    goto(141); expect_q("load_edge140", 1'b1, 1'b1);
    goto(145); bus.d = 1'b0;
    goto(179); expect_q("hold_before180", 1'b1, 1'b1);
    goto(181); expect_q("load0_edge180", 1'b0, 1'b0);
    goto(185); bus.d = 1'b1;
    goto(221); expect_q("load1_edge220", 1'b1, 1'b1);

    // Short clear pulse covering no edge.
    goto(230); bus.rc = 1'b1;
    goto(231); expect_q("pulse_async_drop", 1'b0, 1'b1);
    goto(250); bus.rc = 1'b0;
    goto(251); expect_q("pulse_no_glitch", 1'b0, 1'b1);
    goto(261); expect_q("pulse_recover_260", 1'b1, 1'b1);

    // Clear split: qc immediately, qr at the next edge.
    goto(265); bus.rc = 1'b1;
    goto(266); expect_q("split_immediate", 1'b0, 1'b1);
    goto(299); expect_q("split_before300", 1'b0, 1'b1);
    goto(301); expect_q("split_edge300", 1'b0, 1'b0);

    // Clear release.
    goto(305); bus.rc = 1'b0;
    goto(306); expect_q("release_no_glitch", 1'b0, 1'b0);
    goto(339); expect_q("release_before340", 1'b0, 1'b0);
    goto(341); expect_q("release_edge340", 1'b1, 1'b1);
    goto(345); bus.d = 1'b0;
    goto(381); expect_q("after_rel_d0", 1'b0, 1'b0);
    goto(385); bus.d = 1'b1;
    goto(421); expect_q("after_rel_d1", 1'b1, 1'b1);

    // Priority: rst_n over d, then rc at the first edge after reset release.
    goto(430); rst_n = 1'b0;
    goto(431); expect_q("prio_rst_async", 1'b0, 1'b0);
    goto(461); expect_q("prio_rst_edge460", 1'b0, 1'b0);
    goto(470); rst_n = 1'b1; bus.rc = 1'b1;
    goto(501); expect_q("prio_rc_edge500", 1'b0, 1'b0);
    goto(505); bus.rc = 1'b0;
    goto(541); expect_q("prio_recover_540", 1'b1, 1'b1);

    // Let the monitor drain, then flag any expectation it never reached.
    goto(545);
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fdc_and_fdr

// File: doc/fdc_and_fdr.md
Name: fdc_and_fdr

Overview:
- Pair of D-type registers sharing one data input, one clock and one clear input.
- qc models a Xilinx-style FDC register: the clear acts asynchronously.
- qr models an FDR register: the clear acts synchronously, only at a rising clock edge.
- Used as a primitive-equivalent register block and a teaching reference for the two clear styles. Both registers also obey a global asynchronous active-low reset.

Parameters:
- WIDTH, 1, bit width of d, qc and qr. Each bit is an independent register; the same rc applies to all bits.

Ports:
- clk  input  1  system clock; all register updates happen on its rising edge.
- rst_n  input  1  global reset, asynchronous, active-low; clears both outputs.
- d  input  WIDTH  data input shared by both registers.
- rc  input  1  clear, active-high. Asynchronous for qc, synchronous for qr.
- qc  output  WIDTH  async-clear register output (FDC behaviour).
- qr  output  WIDTH  sync-clear register output (FDR behaviour).

Behaviour:
- Reset:
  - rst_n=0 forces qc=0 and qr=0 immediately, independent of clk, and holds them while low.
  - On rst_n release, both hold 0 until the next qualifying rising clk edge.
  - rst_n has priority over rc and d.
- qc (FDC):
  - Whenever rc=1, qc=0 immediately, with no clock needed, and held for as long as rc=1.
  - With rst_n=1 and rc=0, qc <= d on each rising clk edge; latency 1 edge.
  - When rc deasserts, qc stays 0 until the next rising edge samples d. No glitch back to the old value.
- qr (FDR):
  - With rst_n=1, on each rising clk edge: if rc=1 then qr <= 0, else qr <= d.
  - rc changes between edges have no effect on qr.
  - An rc pulse that covers no rising edge never clears qr.
- Simultaneous events:
  - rc=1 at a clock edge with d=1: both outputs become/stay 0.
  - rc=0 and d=1 at the edge after clear release: both become 1.
- No enable; every clock edge loads.
- Outputs are driven directly from the flops: no combinational path from d to either output. The only combinational path is rc to qc (through the async clear pin).
- Width rule: bitwise; no arithmetic.

Decomposition:
- No shared package required; the reset/clear value is the constant all-zeros, defined locally.
- One natural sub-module, fd_cell: a WIDTH-bit D register with parameter ASYNC_CLR (1 = FDC style, 0 = FDR style).
- Top level instantiates fd_cell twice (ASYNC_CLR=1 -> qc, ASYNC_CLR=0 -> qr), wiring clk, rst_n, d and rc to both.

Test Plan (clk period 40 ns, first rising edge at 20 ns, WIDTH=1):
- Reset: rst_n=0 with d=1 toggling across several edges -> qc=qr=0 throughout. After rst_n=1 mid-cycle, both stay 0 until the next edge samples d.
- Load/track: rc=0, d=1 set at 105 -> qc=qr=1 after edge 140. d=0 at 145 -> both 0 after 180. d=1 at 185 -> both 1 after 220 and still 1 after 260.
- Clear split: rc=1 at 265 with d=1 -> qc=0 immediately at 265; qr stays 1 until edge 300, then 0.
- Clear release: rc=0 at 305, d=1 -> both stay 0 until edge 340, then both 1. Then d=0 at 345 -> both 0 after 380; d=1 at 385 -> both 1 after 420.
- Short clear pulse: rc=1 from 230 to 250 (no edge covered), qc=qr=1 beforehand -> qc drops to 0 and recovers to d at edge 260; qr stays 1 throughout.
- Priority: rst_n=0 while rc=0, d=1 at an edge -> both 0. rst_n=1 and rc=1 at the next edge -> both remain 0.
